// File: rtl/reflet_float_stream_minmax.sv
// Streaming min/max/count reduction over a packet of sign-magnitude float words.
// Optional REFLET_FLOAT_MINMAX_INDEX_EN adds out_min_idx/out_max_idx position outputs.

module reflet_float_comp #(
  parameter int float_size = 32
) (
  input  logic [float_size-1:0] in_a,
  input  logic [float_size-1:0] in_b,
  input  logic [1:0]            order,
  output logic                  result
);

  logic                  signA, signB;
  logic [float_size-2:0] magA, magB;
  logic                  bothZero, aLess, aEqual;

  assign signA    = in_a[float_size-1];
  assign signB    = in_b[float_size-1];
  assign magA     = in_a[float_size-2:0];
  assign magB     = in_b[float_size-2:0];
  assign bothZero = (magA == '0) && (magB == '0);
  assign aEqual   = bothZero || (in_a == in_b);

  // +0 and -0 are equal; otherwise sign decides, then magnitude (reversed for negatives)
  always_comb begin
    aLess = 1'b0;
    if (bothZero)
      aLess = 1'b0;
    else if (signA != signB)
      aLess = signA;
    else if (signA)
      aLess = magA > magB;
    else
      aLess = magA < magB;
  end

  always_comb begin
    result = 1'b0;
    unique case (order)
      2'b10:   result = aLess;
      2'b01:   result = aEqual;
      2'b11:   result = aLess || aEqual;
      default: result = !aLess && !aEqual;
    endcase
  end

endmodule

module reflet_float_stream_minmax #(
  parameter int float_size  = 32,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [float_size-1:0]  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [float_size-1:0]  out_min,
  output logic [float_size-1:0]  out_max,
  output logic [count_width-1:0] out_count,
  output logic                   out_count_sat
`ifdef REFLET_FLOAT_MINMAX_INDEX_EN
  ,
  output logic [count_width-1:0] out_min_idx,
  output logic [count_width-1:0] out_max_idx
`endif
);

  typedef enum logic [1:0] {EMPTY, ACCUM, DONE} state_t;

  state_t                  state_q;
  logic                    inReady_q, outValid_q;
  logic [float_size-1:0]   min_q, max_q;
  logic [count_width-1:0]  count_q, count_d;
  logic                    sat_q, sat_d;
  logic                    newIsLess, newIsMore;

  reflet_float_comp #(.float_size(float_size)) uCompMin (
    .in_a(in_data), .in_b(min_q), .order(2'b10), .result(newIsLess)
  );

  reflet_float_comp #(.float_size(float_size)) uCompMax (
    .in_a(max_q), .in_b(in_data), .order(2'b10), .result(newIsMore)
  );

  assign count_d = (count_q == '1) ? count_q : count_q + count_width'(1);
  assign sat_d   = (count_d == '1);

`ifdef REFLET_FLOAT_MINMAX_INDEX_EN
  logic [count_width-1:0] minIdx_q, maxIdx_q;

  // The incoming word's position equals the count before it, which already saturates at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      minIdx_q <= '0;
      maxIdx_q <= '0;
    end else if (in_valid && inReady_q) begin
      if (state_q == EMPTY) begin
        minIdx_q <= '0;
        maxIdx_q <= '0;
      end else begin
        if (newIsLess) minIdx_q <= count_q;
        if (newIsMore) maxIdx_q <= count_q;
      end
    end
  end

  assign out_min_idx = minIdx_q;
  assign out_max_idx = maxIdx_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      min_q      <= '0;
      max_q      <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY, ACCUM: begin
          if (in_valid) begin
            if (state_q == EMPTY) begin
              min_q   <= in_data;
              max_q   <= in_data;
              count_q <= count_width'(1);
              sat_q   <= 1'b0;
            end else begin
              if (newIsLess) min_q <= in_data;
              if (newIsMore) max_q <= in_data;
              count_q <= count_d;
              sat_q   <= sat_d;
            end
            if (in_last) begin
              state_q    <= DONE;
              inReady_q  <= 1'b0;
              outValid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q    <= EMPTY;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= EMPTY;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = inReady_q;
  assign out_valid     = outValid_q;
  assign out_min       = min_q;
  assign out_max       = max_q;
  assign out_count     = count_q;
  assign out_count_sat = sat_q;

endmodule

// File: tb/tb_reflet_float_stream_minmax.sv
// Self-checking bench for reflet_float_stream_minmax: directed packets, a narrow-counter
// saturation instance, and randomized traffic compared against a packet-level model.

module tb_reflet_float_stream_minmax;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_count_sat;
  logic [31:0] out_min, out_max;
  logic [15:0] out_count;

  logic        in2_valid = 1'b0, in2_last = 1'b0, out2_ready = 1'b0;
  logic [31:0] in2_data = '0;
  logic        in2_ready, out2_valid, out2_count_sat;
  logic [31:0] out2_min, out2_max;
  logic [1:0]  out2_count;

`ifdef REFLET_FLOAT_MINMAX_INDEX_EN
  logic [15:0] out_min_idx, out_max_idx;
  logic [1:0]  out2_min_idx, out2_max_idx;
`endif

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  reflet_float_stream_minmax #(.float_size(32), .count_width(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_count(out_count), .out_count_sat(out_count_sat)
`ifdef REFLET_FLOAT_MINMAX_INDEX_EN
    , .out_min_idx(out_min_idx), .out_max_idx(out_max_idx)
`endif
  );

  reflet_float_stream_minmax #(.float_size(32), .count_width(2)) dutSat (
    .clk(clk), .reset(reset),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data), .in_last(in2_last),
    .out_valid(out2_valid), .out_ready(out2_ready),
    .out_min(out2_min), .out_max(out2_max), .out_count(out2_count), .out_count_sat(out2_count_sat)
`ifdef REFLET_FLOAT_MINMAX_INDEX_EN
    , .out_min_idx(out2_min_idx), .out_max_idx(out2_max_idx)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Real-number ordering of a sign-magnitude word; both zeros map to 0
  function automatic longint fkey(input logic [31:0] w);
    longint m;
    m = longint'(w[30:0]);
    return w[31] ? -m : m;
  endfunction

  // Packet-level reference: 0 = EMPTY, 1 = ACCUM, 2 = DONE
  int          mState = 0;
  logic [31:0] pkt[$];
  logic [31:0] expMin = '0, expMax = '0;
  int          expCount = 0, expMinIdx = 0, expMaxIdx = 0;
  bit          expSat = 1'b0;

  task automatic computeResult();
    expMin = pkt[0];
    expMax = pkt[0];
    expMinIdx = 0;
    expMaxIdx = 0;
    for (int i = 1; i < pkt.size(); i++) begin
      if (fkey(pkt[i]) < fkey(expMin)) begin
        expMin = pkt[i];
        expMinIdx = (i > 65535) ? 65535 : i;
      end
      if (fkey(pkt[i]) > fkey(expMax)) begin
        expMax = pkt[i];
        expMaxIdx = (i > 65535) ? 65535 : i;
      end
    end
    expCount = (pkt.size() > 65535) ? 65535 : pkt.size();
    expSat = (expCount == 65535);
    pkt.delete();
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState = 0;
      pkt.delete();
    end else if (mState == 2) begin
      if (out_ready) mState = 0;
    end else if (in_valid) begin
      pkt.push_back(in_data);
      if (in_last) begin
        computeResult();
        mState = 2;
      end else begin
        mState = 1;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready", 64'(in_ready), 64'(mState != 2));
    checkOutput("out_valid", 64'(out_valid), 64'(mState == 2));
    if (mState == 2) begin
      checkOutput("out_min", 64'(out_min), 64'(expMin));
      checkOutput("out_max", 64'(out_max), 64'(expMax));
      checkOutput("out_count", 64'(out_count), 64'(expCount));
      checkOutput("out_count_sat", 64'(out_count_sat), 64'(expSat));
`ifdef REFLET_FLOAT_MINMAX_INDEX_EN
      checkOutput("out_min_idx", 64'(out_min_idx), 64'(expMinIdx));
      checkOutput("out_max_idx", 64'(out_max_idx), 64'(expMaxIdx));
`endif
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pickWord(input logic [31:0] prev);
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return prev;
      3:       return $urandom & 32'h8000_000F;
      4:       return prev ^ 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] satWords[5];
    logic [31:0] lastWord;
    satWords = '{32'h3F80_0000, 32'hC000_0000, 32'h40A0_0000, 32'hBF80_0000, 32'h4100_0000};

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_min", 64'(out_min), 64'd0);
    checkOutput("rst_out_count", 64'(out_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Mixed-sign three-word packet
    applyStimulus(1'b1, 32'h3F80_0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hC000_0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h4060_0000, 1'b1, 1'b1);
    checkOutput("p1_valid", 64'(out_valid), 64'd1);
    checkOutput("p1_min", 64'(out_min), 64'hC000_0000);
    checkOutput("p1_max", 64'(out_max), 64'h4060_0000);
    checkOutput("p1_count", 64'(out_count), 64'd3);
    checkOutput("p1_model_min", 64'(expMin), 64'hC000_0000);
`ifdef REFLET_FLOAT_MINMAX_INDEX_EN
    checkOutput("p1_min_idx", 64'(out_min_idx), 64'd1);
    checkOutput("p1_max_idx", 64'(out_max_idx), 64'd2);
`endif
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Zeros: tie keeps the first bit pattern
    applyStimulus(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b0);
    checkOutput("zero_min", 64'(out_min), 64'h0);
    checkOutput("zero_max", 64'(out_max), 64'h0);
    checkOutput("zero_count", 64'(out_count), 64'd2);
    checkOutput("zero_model_max", 64'(expMax), 64'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Single word, then backpressure with a pending input word
    applyStimulus(1'b1, 32'h4120_0000, 1'b1, 1'b0);
    checkOutput("single_in_ready", 64'(in_ready), 64'd0);
    checkOutput("single_min", 64'(out_min), 64'h4120_0000);
    checkOutput("single_count", 64'(out_count), 64'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'hBF80_0000, 1'b0, 1'b0);
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_max", 64'(out_max), 64'h4120_0000);
    end
    applyStimulus(1'b1, 32'hBF80_0000, 1'b1, 1'b1);
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("release_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 32'hBF80_0000, 1'b1, 1'b0);
    checkOutput("newpkt_min", 64'(out_min), 64'hBF80_0000);
    checkOutput("newpkt_count", 64'(out_count), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset mid-packet discards the partial packet
    applyStimulus(1'b1, 32'h3F80_0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4000_0000, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_max", 64'(out_max), 64'd0);
    checkOutput("midrst_count", 64'(out_count), 64'd0);
    checkOutput("midrst_sat", 64'(out_count_sat), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 32'hC040_0000, 1'b1, 1'b0);
    checkOutput("postrst_min", 64'(out_min), 64'hC040_0000);
    checkOutput("postrst_max", 64'(out_max), 64'hC040_0000);
    checkOutput("postrst_count", 64'(out_count), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Saturating 2-bit counter over a 5-word packet
    for (int i = 0; i < 5; i++) begin
      in2_valid = 1'b1;
      in2_data  = satWords[i];
      in2_last  = (i == 4);
      @(negedge clk);
    end
    in2_valid = 1'b0;
    in2_last  = 1'b0;
    checkOutput("sat_valid", 64'(out2_valid), 64'd1);
    checkOutput("sat_count", 64'(out2_count), 64'd3);
    checkOutput("sat_flag", 64'(out2_count_sat), 64'd1);
    checkOutput("sat_min", 64'(out2_min), 64'hC000_0000);
    checkOutput("sat_max", 64'(out2_max), 64'h4100_0000);
`ifdef REFLET_FLOAT_MINMAX_INDEX_EN
    checkOutput("sat_min_idx", 64'(out2_min_idx), 64'd1);
    checkOutput("sat_max_idx", 64'(out2_max_idx), 64'd3);
`endif
    out2_ready = 1'b1;
    @(negedge clk);
    checkOutput("sat_release", 64'(in2_ready), 64'd1);

    // Randomized traffic against the packet model
    lastWord = 32'h3F80_0000;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] w;
      w = pickWord(lastWord);
      lastWord = w;
      applyStimulus(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
